trigger_pulse_gen: RTL and testbench
====================================

TRIGGER_PULSE_GEN -- requirements
Module: trigger_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of pulse_width, pulse_gap and fire/missed counters.
REQ-002 SHALL have parameter HOLD_W, default 32, width of holdoff.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 trig_in  input  1  delayed trigger level from the trigger delay stage, synchronous to clk.
REQ-006 pulse_width  input  CNT_W  high time per pulse, in cycles.
REQ-007 pulse_gap  input  CNT_W  low time between pulses of one burst, in cycles.
REQ-008 pulse_count  input  8  pulses per burst; 0 = disabled.
REQ-009 holdoff  input  HOLD_W  dead time after the burst, in cycles.
REQ-010 cfg_update  input  1  one-cycle strobe that loads all four config inputs.
REQ-011 pulse_out  output  1  registered glitch/fault pulse output.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 fire_count  output  CNT_W  bursts started, saturating.
REQ-014 missed_count  output  CNT_W  trigger edges ignored, saturating.

Function
REQ-015 SHALL detect the trig_in rising edge as trig_in=1 with the previous-cycle register=0.
REQ-016 SHALL implement states IDLE, HIGH, GAP and HOLDOFF.
REQ-017 IDLE: an edge at cycle N with active pulse_count>0 -> HIGH, with pulse_out=1 from cycle N+1 (one-cycle latency).
REQ-018 HIGH SHALL last exactly max(pulse_width,1) cycles, then:
- GAP if pulses remain;
- else HOLDOFF if holdoff>0;
- else IDLE.
REQ-019 GAP: pulse_out=0 for exactly max(pulse_gap,1) cycles, then HIGH.
REQ-020 HOLDOFF: pulse_out=0 for exactly holdoff cycles, then IDLE.
REQ-021 An edge arriving in HIGH, GAP or HOLDOFF SHALL be ignored and increment missed_count.
REQ-022 An edge in IDLE with active pulse_count=0 SHALL increment missed_count and stay IDLE.
REQ-023 fire_count SHALL increment on each IDLE->HIGH transition.
REQ-024 Both counters SHALL saturate at 2^CNT_W-1.
REQ-025 cfg_update in IDLE SHALL load the active config at the next edge; it takes effect for edges from the following cycle.
REQ-026 cfg_update while busy SHALL latch into a pending register (last strobe wins).
- The pending config is applied on the cycle of the return to IDLE.
- The burst in progress is unaffected.
REQ-027 cfg_update and an edge in the same IDLE cycle: the edge SHALL use the old config.
REQ-028 Internal width/gap/holdoff counters SHALL be sized to their inputs with no wrap-around.
- The pulse index is 8-bit.
- pulse_count=255 SHALL produce exactly 255 pulses.
REQ-029 pulse_out SHALL be driven directly from a flop.

Reset
REQ-030 On rst SHALL force:
- state=IDLE, pulse_out=0, busy=0;
- fire_count=0, missed_count=0;
- active and pending config=0, so the block is disabled until the first cfg_update;
- pending flag=0.
REQ-031 The previous-trig register SHALL reset to 1, so trig_in held high through reset gives no edge.
REQ-032 rst asserted mid-burst SHALL drop pulse_out asynchronously in the same cycle; no pulse resumes after release.

Structure
REQ-033 The state enum and default constants SHALL live in the shared trigger_delay_pkg, alongside the existing edge/command definitions.
REQ-034 Counters SHALL be inline; no sub-module is required.

Verification
REQ-035 Load width=3, gap=2, count=2, holdoff=0; edge at N -> pulse_out high N+1..N+3 and N+6..N+8, busy low at N+9, fire_count=1.
REQ-036 Load width=0, gap=0, count=3 -> three 1-cycle pulses separated by 1 low cycle.
REQ-037 Load width=2, count=1, holdoff=10; second edge 5 cycles after the first -> no pulse, missed_count=1; edge at the first IDLE cycle -> new pulse.
REQ-038 Load count=0, then edge -> pulse_out stays 0, missed_count=1, fire_count=0.
REQ-039 cfg_update(width=5) issued mid-burst of width=2 -> current burst keeps 2-cycle pulses, next burst uses 5.
REQ-040 Assert rst during HIGH with trig_in held high -> pulse_out=0 immediately; after release no pulse until a fresh 0->1 edge.

Source files
------------

// File: rtl/trigger_delay_pkg.sv
// Shared definitions for the trigger delay / pulse generation path:
// edge and command encodings plus the pulse generator state machine.
package trigger_delay_pkg;

  // Edge polarity selection used by the trigger delay stage
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2,
    EDGE_NONE = 2'd3
  } edge_sel_e;

  // Host command encodings for the trigger path
  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_ARM   = 2'd1,
    CMD_DISARM = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_e;

  // Pulse generator states
  typedef enum logic [1:0] {
    PG_IDLE    = 2'd0,
    PG_HIGH    = 2'd1,
    PG_GAP     = 2'd2,
    PG_HOLDOFF = 2'd3
  } pg_state_e;

  // Default widths of the pulse generator counters
  localparam int PG_CNT_W_DEF  = 16;
  localparam int PG_HOLD_W_DEF = 32;

  // True when the pulse with index idx is the final pulse of a burst of cnt pulses
  function automatic logic is_last_pulse(input logic [7:0] idx, input logic [7:0] cnt);
    return (idx == (cnt - 8'd1));
  endfunction

endpackage

// File: rtl/trigger_pulse_gen.sv
// Trigger pulse generator: on a rising trig_in edge emits a burst of
// pulse_count pulses (width/gap programmable) followed by a hold-off period.
// Configuration is double buffered so a burst in flight is never disturbed.
module trigger_pulse_gen
  import trigger_delay_pkg::*;
#(
  parameter int CNT_W  = PG_CNT_W_DEF,
  parameter int HOLD_W = PG_HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_in,
  input  logic [CNT_W-1:0]  pulse_width,
  input  logic [CNT_W-1:0]  pulse_gap,
  input  logic [7:0]        pulse_count,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              cfg_update,
  output logic              pulse_out,
  output logic              busy,
  output logic [CNT_W-1:0]  fire_count,
  output logic [CNT_W-1:0]  missed_count
);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

  pg_state_e          state_q, state_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               trig_prev_q, trig_prev_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   fire_q, fire_d;
  logic [CNT_W-1:0]   missed_q, missed_d;

  // Active configuration (used by bursts) and pending configuration
  logic [CNT_W-1:0]   act_width_q, act_width_d;
  logic [CNT_W-1:0]   act_gap_q, act_gap_d;
  logic [7:0]         act_count_q, act_count_d;
  logic [HOLD_W-1:0]  act_hold_q, act_hold_d;
  logic [CNT_W-1:0]   pend_width_q, pend_width_d;
  logic [CNT_W-1:0]   pend_gap_q, pend_gap_d;
  logic [7:0]         pend_count_q, pend_count_d;
  logic [HOLD_W-1:0]  pend_hold_q, pend_hold_d;
  logic               pend_valid_q, pend_valid_d;

  logic               edge_s;
  logic               start_s;
  logic               miss_s;
  logic               to_idle_s;
  logic [CNT_W-1:0]   width_m1_s;
  logic [CNT_W-1:0]   gap_m1_s;

  // Next-state, counter and configuration update logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_cnt_d   = hold_cnt_q;
    idx_d        = idx_q;
    fire_d       = fire_q;
    missed_d     = missed_q;
    act_width_d  = act_width_q;
    act_gap_d    = act_gap_q;
    act_count_d  = act_count_q;
    act_hold_d   = act_hold_q;
    pend_width_d = pend_width_q;
    pend_gap_d   = pend_gap_q;
    pend_count_d = pend_count_q;
    pend_hold_d  = pend_hold_q;
    pend_valid_d = pend_valid_q;
    to_idle_s    = 1'b0;
    trig_prev_d  = trig_in;

    edge_s  = trig_in & ~trig_prev_q;
    start_s = edge_s & (state_q == PG_IDLE) & (act_count_q != 8'd0);
    miss_s  = edge_s & ~start_s;

    // Zero width/gap behave as one cycle; counters hold "cycles remaining - 1"
    width_m1_s = (act_width_q == CNT_ZERO) ? CNT_ZERO : (act_width_q - CNT_ONE);
    gap_m1_s   = (act_gap_q == CNT_ZERO) ? CNT_ZERO : (act_gap_q - CNT_ONE);

    case (state_q)
      PG_IDLE: begin
        if (start_s) begin
          state_d = PG_HIGH;
          cnt_d   = width_m1_s;
          idx_d   = 8'd0;
        end else begin
          state_d = PG_IDLE;
        end
      end
      PG_HIGH: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!is_last_pulse(idx_q, act_count_q)) begin
          state_d = PG_GAP;
          cnt_d   = gap_m1_s;
        end else if (act_hold_q != HOLD_ZERO) begin
          state_d    = PG_HOLDOFF;
          hold_cnt_d = act_hold_q - HOLD_ONE;
        end else begin
          state_d   = PG_IDLE;
          to_idle_s = 1'b1;
        end
      end
      PG_GAP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = PG_HIGH;
          cnt_d   = width_m1_s;
          idx_d   = idx_q + 8'd1;
        end
      end
      PG_HOLDOFF: begin
        if (hold_cnt_q != HOLD_ZERO) begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end else begin
          state_d   = PG_IDLE;
          to_idle_s = 1'b1;
        end
      end
      default: begin
        state_d = PG_IDLE;
      end
    endcase

    // Idle and not launching: load directly. Returning to idle: newest strobe wins.
    // Otherwise park the strobe in the pending set so the burst is untouched.
    if (cfg_update) begin
      if (((state_q == PG_IDLE) && !start_s) || to_idle_s) begin
        act_width_d  = pulse_width;
        act_gap_d    = pulse_gap;
        act_count_d  = pulse_count;
        act_hold_d   = holdoff;
        pend_valid_d = 1'b0;
      end else begin
        pend_width_d = pulse_width;
        pend_gap_d   = pulse_gap;
        pend_count_d = pulse_count;
        pend_hold_d  = holdoff;
        pend_valid_d = 1'b1;
      end
    end else if (to_idle_s && pend_valid_q) begin
      act_width_d  = pend_width_q;
      act_gap_d    = pend_gap_q;
      act_count_d  = pend_count_q;
      act_hold_d   = pend_hold_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    if (start_s && (fire_q != CNT_MAX)) begin
      fire_d = fire_q + CNT_ONE;
    end else begin
      fire_d = fire_q;
    end

    if (miss_s && (missed_q != CNT_MAX)) begin
      missed_d = missed_q + CNT_ONE;
    end else begin
      missed_d = missed_q;
    end

    pulse_d = (state_d == PG_HIGH);
    busy_d  = (state_d != PG_IDLE);
  end

  // State, counters, configuration and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PG_IDLE;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      trig_prev_q  <= 1'b1;
      cnt_q        <= CNT_ZERO;
      hold_cnt_q   <= HOLD_ZERO;
      idx_q        <= 8'd0;
      fire_q       <= CNT_ZERO;
      missed_q     <= CNT_ZERO;
      act_width_q  <= CNT_ZERO;
      act_gap_q    <= CNT_ZERO;
      act_count_q  <= 8'd0;
      act_hold_q   <= HOLD_ZERO;
      pend_width_q <= CNT_ZERO;
      pend_gap_q   <= CNT_ZERO;
      pend_count_q <= 8'd0;
      pend_hold_q  <= HOLD_ZERO;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulse_q      <= pulse_d;
      busy_q       <= busy_d;
      trig_prev_q  <= trig_prev_d;
      cnt_q        <= cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      idx_q        <= idx_d;
      fire_q       <= fire_d;
      missed_q     <= missed_d;
      act_width_q  <= act_width_d;
      act_gap_q    <= act_gap_d;
      act_count_q  <= act_count_d;
      act_hold_q   <= act_hold_d;
      pend_width_q <= pend_width_d;
      pend_gap_q   <= pend_gap_d;
      pend_count_q <= pend_count_d;
      pend_hold_q  <= pend_hold_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign pulse_out    = pulse_q;
  assign busy         = busy_q;
  assign fire_count   = fire_q;
  assign missed_count = missed_q;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Self-checking bench for trigger_pulse_gen. A behavioural model predicts each
// burst as an arithmetic schedule (start cycle, period, pulse count, end cycle).
module tb_trigger_pulse_gen;

  localparam int CW  = 4;
  localparam int HW  = 8;
  localparam int SAT = 15;

  logic          clk;
  logic          rst;
  logic          trig_in;
  logic [CW-1:0] pulse_width;
  logic [CW-1:0] pulse_gap;
  logic [7:0]    pulse_count;
  logic [HW-1:0] holdoff;
  logic          cfg_update;
  logic          pulse_out;
  logic          busy;
  logic [CW-1:0] fire_count;
  logic [CW-1:0] missed_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int cyc;
  int m_act_w, m_act_g, m_act_c, m_act_h;
  int m_pend_w, m_pend_g, m_pend_c, m_pend_h;
  bit m_pend_v;
  bit m_prev;
  int m_idle_at;
  bit m_burst_on;
  int m_bs, m_bw, m_bg, m_bc;
  int m_fire, m_missed;

  trigger_pulse_gen #(.CNT_W(CW), .HOLD_W(HW)) dut (
    .clk          (clk),
    .rst          (rst),
    .trig_in      (trig_in),
    .pulse_width  (pulse_width),
    .pulse_gap    (pulse_gap),
    .pulse_count  (pulse_count),
    .holdoff      (holdoff),
    .cfg_update   (cfg_update),
    .pulse_out    (pulse_out),
    .busy         (busy),
    .fire_count   (fire_count),
    .missed_count (missed_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pulse level in cycle c from the current burst schedule
  function automatic bit exp_pulse(input int c);
    int we, ge, t, k, r;
    if (!m_burst_on || c <= m_bs) return 1'b0;
    we = (m_bw < 1) ? 1 : m_bw;
    ge = (m_bg < 1) ? 1 : m_bg;
    t  = c - m_bs - 1;
    k  = t / (we + ge);
    r  = t % (we + ge);
    return (k < m_bc) && (r < we);
  endfunction

  task automatic model_reset();
    m_act_w = 0; m_act_g = 0; m_act_c = 0; m_act_h = 0;
    m_pend_w = 0; m_pend_g = 0; m_pend_c = 0; m_pend_h = 0;
    m_pend_v = 1'b0; m_prev = 1'b1; m_idle_at = 0; m_burst_on = 1'b0;
    m_fire = 0; m_missed = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs
  task automatic step(input logic t, input logic cu);
    bit idle, fired;
    int we, ge;
    logic [CW-1:0] ef, em;
    trig_in = t;
    cfg_update = cu;
    idle = (cyc >= m_idle_at);
    if (idle && m_pend_v) begin
      m_act_w = m_pend_w; m_act_g = m_pend_g; m_act_c = m_pend_c; m_act_h = m_pend_h;
      m_pend_v = 1'b0;
    end
    fired = 1'b0;
    if (t && !m_prev) begin
      if (idle && m_act_c > 0) begin
        fired = 1'b1;
        m_burst_on = 1'b1;
        m_bs = cyc; m_bw = m_act_w; m_bg = m_act_g; m_bc = m_act_c;
        we = (m_bw < 1) ? 1 : m_bw;
        ge = (m_bg < 1) ? 1 : m_bg;
        m_idle_at = cyc + 1 + m_bc * we + (m_bc - 1) * ge + m_act_h;
        if (m_fire < SAT) m_fire++;
      end else begin
        if (m_missed < SAT) m_missed++;
      end
    end
    if (cu) begin
      if (idle && !fired) begin
        m_act_w = int'(pulse_width); m_act_g = int'(pulse_gap);
        m_act_c = int'(pulse_count); m_act_h = int'(holdoff);
      end else begin
        m_pend_w = int'(pulse_width); m_pend_g = int'(pulse_gap);
        m_pend_c = int'(pulse_count); m_pend_h = int'(holdoff);
        m_pend_v = 1'b1;
      end
    end
    m_prev = t;
    @(posedge clk);
    #1;
    cyc++;
    ef = m_fire[CW-1:0];
    em = m_missed[CW-1:0];
    checks++;
    if (pulse_out !== exp_pulse(cyc)) begin
      errors++;
      $display("FAIL pulse_out cyc=%0d got=%b exp=%b", cyc, pulse_out, exp_pulse(cyc));
    end
    checks++;
    if (busy !== (cyc < m_idle_at)) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc < m_idle_at));
    end
    checks++;
    if (fire_count !== ef) begin
      errors++;
      $display("FAIL fire_count cyc=%0d got=%0d exp=%0d", cyc, fire_count, ef);
    end
    checks++;
    if (missed_count !== em) begin
      errors++;
      $display("FAIL missed_count cyc=%0d got=%0d exp=%0d", cyc, missed_count, em);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic load_cfg(input int w, input int g, input int c, input int h);
    pulse_width = w[CW-1:0];
    pulse_gap   = g[CW-1:0];
    pulse_count = c[7:0];
    holdoff     = h[HW-1:0];
    step(trig_in, 1'b1);
  endtask

  // Assert reset asynchronously (trig level held), check immediate effect, release
  task automatic do_reset(input logic t);
    trig_in = t;
    cfg_update = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (pulse_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse_out got=%b exp=0", pulse_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (fire_count !== '0 || missed_count !== '0) begin
      errors++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", fire_count, missed_count);
    end
    rst = 1'b0;
    cyc += 2;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    do_reset(1'b0);
    // Block is disabled until the first configuration load
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle_cycles(3);
  endtask

  task automatic test_basic();
    int f0;
    bit seen;
    f0 = m_fire;
    load_cfg(3, 2, 2, 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle_cycles(10);
    checks++;
    if (fire_count !== 4'(f0 + 1)) begin
      errors++;
      $display("FAIL basic_fire got=%0d exp=%0d", fire_count, f0 + 1);
    end
    seen = 1'b0;
  endtask

  task automatic test_min_width();
    load_cfg(0, 0, 3, 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle_cycles(8);
  endtask

  task automatic test_holdoff();
    load_cfg(2, 0, 1, 10);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);      // edge N
    idle_cycles(4);        // N+1..N+4
    step(1'b1, 1'b0);      // N+5, ignored
    idle_cycles(7);        // N+6..N+12
    step(1'b1, 1'b0);      // N+13, first idle cycle
    idle_cycles(16);
  endtask

  task automatic test_disabled();
    int mb;
    load_cfg(3, 1, 0, 2);
    step(1'b0, 1'b0);
    mb = m_missed;
    step(1'b1, 1'b0);
    idle_cycles(3);
    checks++;
    if (missed_count !== 4'(mb + 1)) begin
      errors++;
      $display("FAIL disabled_missed got=%0d exp=%0d", missed_count, mb + 1);
    end
  endtask

  task automatic test_cfg_midburst();
    load_cfg(2, 1, 3, 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle_cycles(2);
    pulse_width = 4'd5;
    step(1'b0, 1'b1);
    idle_cycles(12);
    step(1'b1, 1'b0);
    idle_cycles(24);
  endtask

  task automatic test_back_to_back();
    load_cfg(1, 1, 1, 0);
    step(1'b0, 1'b0);
    pulse_width = 4'd4;
    step(1'b1, 1'b1);      // edge uses old width, new width parked
    idle_cycles(6);
    step(1'b1, 1'b0);
    idle_cycles(8);
  endtask

  task automatic test_count255();
    load_cfg(0, 0, 255, 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle_cycles(515);
  endtask

  task automatic test_reset_midburst();
    load_cfg(4, 1, 2, 3);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    do_reset(1'b1);
    load_cfg(2, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle_cycles(6);
  endtask

  task automatic test_random();
    logic t;
    logic cu;
    for (int i = 0; i < 900; i++) begin
      cu = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        pulse_width = 4'($urandom_range(0, 5));
        pulse_gap   = 4'($urandom_range(0, 5));
        pulse_count = 8'($urandom_range(0, 4));
        holdoff     = 8'($urandom_range(0, 8));
        cu = 1'b1;
      end
      t = ($urandom_range(0, 3) == 0) ? ~trig_in : trig_in;
      step(t, cu);
    end
  endtask

  initial begin
    rst = 1'b1;
    trig_in = 1'b0;
    cfg_update = 1'b0;
    pulse_width = '0;
    pulse_gap = '0;
    pulse_count = 8'd0;
    holdoff = '0;
    cyc = 0;
    model_reset();
    test_reset();
    test_basic();
    test_min_width();
    test_holdoff();
    test_disabled();
    test_cfg_midburst();
    test_back_to_back();
    test_count255();
    test_reset_midburst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
